imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Encoder and writer for the single-cycle CPU's instruction memory: it is the producing end of the opcode/func decode path.
- Accepts symbolic instruction commands (mnemonic ID plus fields) over a valid/ready handshake.
- Encodes each command into a 32-bit MIPS word and writes it to sequential instruction-memory addresses.
- Expands the `li` pseudo-op into `lui`+`ori`. Used by bench/boot logic to load programs without a precompiled image.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  synchronous clear of write address, count and error; highest priority after rst
op_valid  in  1  command valid
op_ready  out  1  loader can accept a command this cycle
op_id  in  5  mnemonic ID (see Behaviour)
rs  in  5  source register field
rt  in  5  target register field
rd  in  5  destination register field
shamt  in  5  shift amount
imm  in  32  immediate; low 16 bits used except by li
target  in  26  jump target field
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  encoded instruction word
words_written  out  ADDR_W+1  count of words written since rst/start
full  out  1  all 2**ADDR_W words written
err  out  1  sticky: illegal op_id or li overflow

Behaviour:
- Reset (async, rst=1): state IDLE; op_ready=0 while rst high; imem_we=0; imem_addr=0; imem_wdata=0; words_written=0; full=0; err=0.
- Handshake: a command is accepted on a rising edge with op_valid&&op_ready. op_ready=1 only when state is IDLE, full=0 and start=0. op_valid may be held high; fields are sampled only at acceptance.
- Latency: the encoded word is registered. imem_we pulses high for exactly 1 cycle, the cycle after acceptance, with imem_addr equal to the current write pointer. The pointer and words_written increment on the same edge that ends that pulse.
- Mnemonic IDs and encodings:
  - 0 and, 1 or, 2 add, 3 xor, 4 nor, 5 sub, 6 slt: R-type {000000,rs,rt,rd,00000,func}. func is 100100/100101/100000/100110/100111/100010/101010 respectively.
  - 7 srl, 8 sll: {000000,00000,rt,rd,shamt,000010/000000}.
  - 9 jr: {000000,rs,15'b0,001000}.
  - 10 lw (100011), 11 sw (101011), 12 beq (000100), 13 bne (000101), 14 addi (001000), 15 ori (001101): {op,rs,rt,imm[15:0]}.
  - 16 lui: {001111,00000,rt,imm[15:0]}.
  - 17 j: {000010,target}. 18 jal: {000011,target}.
  - 19 li: if imm[31:16]==0, a single word ori rt,$0,imm[15:0]. Otherwise two words: lui rt,imm[31:16], then ori rt,rt,imm[15:0].
  - 20 nop: 32'h0.
  - 21..31: illegal.
- FSM:
  - IDLE –accept→ EMIT.
  - EMIT (we=1) → IDLE, or → EMIT2 if a two-word li.
  - EMIT2 (we=1, ori word, address+1) → IDLE.
  - op_ready=0 in EMIT and EMIT2.
- Illegal op_id: the command is consumed, err set, nothing written, state stays IDLE.
- Overflow: a two-word li accepted with exactly one free slot is consumed with err set and no write, so it is never half-written.
- full asserts on the edge where words_written reaches 2**ADDR_W. No wrap-around: further commands stall (op_ready=0) until start.
- start: in IDLE it clears the pointer, words_written, full and err next edge. If asserted during EMIT/EMIT2, the in-flight write(s) complete, then the clear applies on return to IDLE; start must be held until then.
- rst mid-li (in EMIT2): the second word is not written; all state returns to reset values.

Decomposition:
- Shared package holds:
  - mnemonic ID localparams (ID_AND..ID_NOP);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_J, OP_JAL);
  - func constants (FN_AND..FN_JR);
  - the FSM state encoding.
- Opcode/func values must match the CPU decoder exactly.
- One combinational sub-module, instr_encode, maps op_id plus fields to word0, word1, two_word and illegal. The top holds the FSM, pointer and handshake.

Test Plan:
- rst, then add rs=1 rt=2 rd=3 → one cycle later imem_we=1, addr=0, wdata=0x00221820; words_written=1.
- li rt=8 imm=0x12345678 → addr 0: 0x3C081234, addr 1: 0x35085678 on consecutive cycles; op_ready low for 2 cycles.
- li rt=8 imm=0x0000ABCD → single write 0x3408ABCD; then jal target=0x0100000 → 0x0C100000; sll rt=3 rd=2 shamt=4 → 0x00031100; beq rs=1 rt=2 imm=0xFFFF → 0x1022FFFF.
- ADDR_W=2: write 3 words, then li with imm[31:16]≠0 → err=1, no write, full=0. Then nop → write at addr 3, full=1, op_ready=0. Then start → addr 0, err=0, full=0.
- op_id=25 → err=1, imem_we stays 0, op_ready back to 1 the next cycle.
- Assert rst during EMIT2 of li → no second write, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared constants for the instruction-memory loader: mnemonic IDs, MIPS opcode/func
// fields as the CPU decoder expects them, the loader FSM encoding, and field packers.
package imem_program_loader_pkg;

    localparam logic [4:0] ID_AND  = 5'd0;
    localparam logic [4:0] ID_OR   = 5'd1;
    localparam logic [4:0] ID_ADD  = 5'd2;
    localparam logic [4:0] ID_XOR  = 5'd3;
    localparam logic [4:0] ID_NOR  = 5'd4;
    localparam logic [4:0] ID_SUB  = 5'd5;
    localparam logic [4:0] ID_SLT  = 5'd6;
    localparam logic [4:0] ID_SRL  = 5'd7;
    localparam logic [4:0] ID_SLL  = 5'd8;
    localparam logic [4:0] ID_JR   = 5'd9;
    localparam logic [4:0] ID_LW   = 5'd10;
    localparam logic [4:0] ID_SW   = 5'd11;
    localparam logic [4:0] ID_BEQ  = 5'd12;
    localparam logic [4:0] ID_BNE  = 5'd13;
    localparam logic [4:0] ID_ADDI = 5'd14;
    localparam logic [4:0] ID_ORI  = 5'd15;
    localparam logic [4:0] ID_LUI  = 5'd16;
    localparam logic [4:0] ID_J    = 5'd17;
    localparam logic [4:0] ID_JAL  = 5'd18;
    localparam logic [4:0] ID_LI   = 5'd19;
    localparam logic [4:0] ID_NOP  = 5'd20;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_EMIT2 = 2'd2
    } state_t;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, shamt, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

endpackage

// File: rtl/imem_program_loader_instr_encode.sv
// Combinational encoder: mnemonic ID plus operand fields to one or two MIPS words.
module imem_program_loader_instr_encode
    import imem_program_loader_pkg::*;
(
    input  logic [4:0]  op_id_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [31:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word0_o,
    output logic [31:0] word1_o,
    output logic        two_word_o,
    output logic        illegal_o
);

    always_comb begin
        word0_o    = 32'h0;
        word1_o    = 32'h0;
        two_word_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_id_i)
            ID_AND:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            ID_OR:   word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            ID_ADD:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            ID_XOR:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            ID_NOR:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            ID_SUB:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            ID_SLT:  word0_o = enc_r(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            ID_SRL:  word0_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            ID_SLL:  word0_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            ID_JR:   word0_o = enc_r(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            ID_LW:   word0_o = enc_i(OP_LW, rs_i, rt_i, imm_i[15:0]);
            ID_SW:   word0_o = enc_i(OP_SW, rs_i, rt_i, imm_i[15:0]);
            ID_BEQ:  word0_o = enc_i(OP_BEQ, rs_i, rt_i, imm_i[15:0]);
            ID_BNE:  word0_o = enc_i(OP_BNE, rs_i, rt_i, imm_i[15:0]);
            ID_ADDI: word0_o = enc_i(OP_ADDI, rs_i, rt_i, imm_i[15:0]);
            ID_ORI:  word0_o = enc_i(OP_ORI, rs_i, rt_i, imm_i[15:0]);
            ID_LUI:  word0_o = enc_i(OP_LUI, 5'd0, rt_i, imm_i[15:0]);
            ID_J:    word0_o = {OP_J, target_i};
            ID_JAL:  word0_o = {OP_JAL, target_i};
            ID_LI: begin
                // A zero upper half fits in a single ori from $0.
                if (imm_i[31:16] == 16'h0) begin
                    word0_o = enc_i(OP_ORI, 5'd0, rt_i, imm_i[15:0]);
                end else begin
                    two_word_o = 1'b1;
                    word0_o    = enc_i(OP_LUI, 5'd0, rt_i, imm_i[31:16]);
                    word1_o    = enc_i(OP_ORI, rt_i, rt_i, imm_i[15:0]);
                end
            end
            ID_NOP:  word0_o = 32'h0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Accepts symbolic instruction commands and writes their encodings to consecutive
// instruction-memory words; li may expand to two words and is never half-written.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_id,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [31:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word1_q, word1_d;
    logic              two_q, two_d;

    logic [31:0] enc_word0;
    logic [31:0] enc_word1;
    logic        enc_two_word;
    logic        enc_illegal;

    imem_program_loader_instr_encode u_instr_encode (
        .op_id_i    (op_id),
        .rs_i       (rs),
        .rt_i       (rt),
        .rd_i       (rd),
        .shamt_i    (shamt),
        .imm_i      (imm),
        .target_i   (target),
        .word0_o    (enc_word0),
        .word1_o    (enc_word1),
        .two_word_o (enc_two_word),
        .illegal_o  (enc_illegal)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        word1_d  = word1_q;
        two_d    = two_q;
        op_ready = !rst && (state_q == ST_IDLE) && !full_q && !start;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (op_valid && op_ready) begin
                    // Illegal IDs and a two-word li into the last slot are swallowed.
                    if (enc_illegal || (enc_two_word && count_q == LAST_SLOT)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        wdata_d = enc_word0;
                        word1_d = enc_word1;
                        two_d   = enc_two_word;
                    end
                end
            end
            ST_EMIT, ST_EMIT2: begin
                ptr_d   = ptr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
                full_d  = (count_d == CAPACITY);
                if (state_q == ST_EMIT && two_q) begin
                    state_d = ST_EMIT2;
                    wdata_d = word1_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0;
            word1_q <= 32'h0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            word1_q <= word1_d;
            two_q   <= two_d;
        end
    end

    assign imem_we       = (state_q != ST_IDLE);
    assign imem_addr     = ptr_q;
    assign imem_wdata    = wdata_q;
    assign words_written = count_q;
    assign full          = full_q;
    assign err           = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed program fragments plus random commands,
// all checked every cycle against a queue-based model of the loader.
module tb_imem_program_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op_valid;
    logic          op_ready;
    logic [4:0]    op_id;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [31:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_written;
    logic          full;
    logic          err;

    imem_program_loader #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_id         (op_id),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .imm           (imm),
        .target        (target),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .words_written (words_written),
        .full          (full),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         wlog[$];
    logic        last_ready;
    bit          accepted;

    // Model: words still to be emitted, plus counters and flags.
    bit          m_active;
    logic [31:0] m_cur;
    logic [31:0] m_rest[$];
    int          m_count;
    bit          m_full;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void ref_encode(input int id, input int s, input int t, input int d,
                                       input int sh, input logic [31:0] im, input logic [25:0] tg,
                                       output int n, output logic [31:0] w0, output logic [31:0] w1);
        int          fn;
        int          op;
        logic [31:0] lo;
        logic [31:0] hi;
        n  = 1;
        w0 = 32'h0;
        w1 = 32'h0;
        lo = im & 32'hFFFF;
        hi = im >> 16;
        if (id <= 6) begin
            case (id)
                0: fn = 'h24;
                1: fn = 'h25;
                2: fn = 'h20;
                3: fn = 'h26;
                4: fn = 'h27;
                5: fn = 'h22;
                default: fn = 'h2A;
            endcase
            w0 = 32'(s) * (1 << 21) + 32'(t) * (1 << 16) + 32'(d) * (1 << 11) + 32'(fn);
        end else if (id == 7 || id == 8) begin
            w0 = 32'(t) * (1 << 16) + 32'(d) * (1 << 11) + 32'(sh) * (1 << 6) + ((id == 7) ? 32'd2 : 32'd0);
        end else if (id == 9) begin
            w0 = 32'(s) * (1 << 21) + 32'd8;
        end else if (id <= 15) begin
            case (id)
                10: op = 'h23;
                11: op = 'h2B;
                12: op = 'h04;
                13: op = 'h05;
                14: op = 'h08;
                default: op = 'h0D;
            endcase
            w0 = 32'(op) * (1 << 26) + 32'(s) * (1 << 21) + 32'(t) * (1 << 16) + lo;
        end else if (id == 16) begin
            w0 = 32'h0F * (1 << 26) + 32'(t) * (1 << 16) + lo;
        end else if (id == 17 || id == 18) begin
            w0 = ((id == 17) ? 32'd2 : 32'd3) * (1 << 26) + 32'(tg);
        end else if (id == 19) begin
            if (hi == 0) begin
                w0 = 32'h0D * (1 << 26) + 32'(t) * (1 << 16) + lo;
            end else begin
                n  = 2;
                w0 = 32'h0F * (1 << 26) + 32'(t) * (1 << 16) + hi;
                w1 = 32'h0D * (1 << 26) + 32'(t) * (1 << 21) + 32'(t) * (1 << 16) + lo;
            end
        end else if (id == 20) begin
            w0 = 32'h0;
        end else begin
            n = 0;
        end
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_cur    = 32'h0;
        m_rest.delete();
        m_count  = 0;
        m_full   = 0;
        m_err    = 0;
    endtask

    task automatic model_step();
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        accepted = 0;
        if (rst) begin
            model_reset();
        end else if (m_active) begin
            m_count++;
            m_full = (m_count == CAP);
            if (m_rest.size() > 0) m_cur = m_rest.pop_front();
            else m_active = 0;
        end else if (start) begin
            m_count = 0;
            m_err   = 0;
            m_full  = 0;
        end else if (op_valid && !m_full) begin
            accepted = 1;
            ref_encode(int'(op_id), int'(rs), int'(rt), int'(rd), int'(shamt), imm, target, n, w0, w1);
            if (n == 0 || (n == 2 && m_count == CAP - 1)) begin
                m_err = 1;
            end else begin
                m_active = 1;
                m_cur    = w0;
                if (n == 2) m_rest.push_back(w1);
            end
        end
    endtask

    task automatic compare();
        logic exp_ready;
        wr_t  w;
        exp_ready = !rst && !m_active && !m_full && !start;
        check("imem_we", imem_we, m_active);
        if (m_active) begin
            check("imem_addr", imem_addr, m_count % CAP);
            check("imem_wdata", imem_wdata, m_cur);
            w.addr = int'(imem_addr);
            w.data = imem_wdata;
            wlog.push_back(w);
            $display("write addr=%0d data=%h", imem_addr, imem_wdata);
        end
        check("words_written", words_written, m_count);
        check("full", full, m_full);
        check("err", err, m_err);
        check("op_ready", op_ready, exp_ready);
        last_ready = op_ready;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input int id, input int s, input int t, input int d, input int sh,
                        input logic [31:0] im, input logic [25:0] tg);
        bit got;
        op_id    = 5'(id);
        rs       = 5'(s);
        rt       = 5'(t);
        rd       = 5'(d);
        shamt    = 5'(sh);
        imm      = im;
        target   = tg;
        op_valid = 1'b1;
        got      = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            cycle();
            got = accepted;
        end
        op_valid = 1'b0;
        $display("command id=%0d accepted=%0d", id, got);
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout: id=%0d never accepted, expected acceptance", id);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic check_log(input string name, input int idx, input int addr, input logic [31:0] data);
        if (idx < wlog.size()) begin
            check({name, "_addr"}, wlog[idx].addr, addr);
            check({name, "_data"}, wlog[idx].data, data);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write %0d missing, log has %0d entries", name, idx, wlog.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        rst = 1'b1; start = 1'b0; op_valid = 1'b0;
        op_id = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 32'h0; target = 26'h0;
        model_reset();
        @(negedge clk);
        cycle();
        #1;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_words", words_written, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_ready", op_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // add $3,$1,$2
        wlog.delete();
        send(2, 1, 2, 3, 0, 32'h0, 26'h0);
        cycle();
        cycle();
        check("add_count", wlog.size(), 1);
        check_log("add", 0, 0, 32'h00221820);
        check("add_words", words_written, 1);

        // li with a non-zero upper half: two words, op_ready low for two cycles
        pulse_start();
        wlog.delete();
        send(19, 0, 8, 0, 0, 32'h12345678, 26'h0);
        lowcnt = 0;
        repeat (3) begin
            cycle();
            if (!last_ready) lowcnt++;
        end
        check("li2_ready_low", lowcnt, 2);
        check_log("li2_w0", 0, 0, 32'h3C081234);
        check_log("li2_w1", 1, 1, 32'h35085678);

        // Three words, then an overflowing li, then nop fills the last slot
        pulse_start();
        wlog.delete();
        send(19, 0, 8, 0, 0, 32'h0000ABCD, 26'h0);
        send(18, 0, 0, 0, 0, 32'h0, 26'h0100000);
        send(8, 0, 3, 2, 4, 32'h0, 26'h0);
        send(19, 0, 9, 0, 0, 32'h00010002, 26'h0);
        cycle();
        check("ovf_err", err, 1);
        check("ovf_full", full, 0);
        check("ovf_words", words_written, 3);
        check("ovf_count", wlog.size(), 3);
        check_log("li1", 0, 0, 32'h3408ABCD);
        check_log("jal", 1, 1, 32'h0C100000);
        check_log("sll", 2, 2, 32'h00031100);
        send(20, 0, 0, 0, 0, 32'h0, 26'h0);
        cycle();
        cycle();
        check_log("nop", 3, 3, 32'h00000000);
        check("full_set", full, 1);
        check("full_ready", op_ready, 0);
        pulse_start();
        #1;
        check("clr_addr", imem_addr, 0);
        check("clr_err", err, 0);
        check("clr_full", full, 0);
        check("clr_words", words_written, 0);
        @(negedge clk);

        wlog.delete();
        send(12, 1, 2, 0, 0, 32'h0000FFFF, 26'h0);
        cycle();
        check_log("beq", 0, 0, 32'h1022FFFF);

        // Illegal ID
        pulse_start();
        wlog.delete();
        send(25, 1, 1, 1, 1, 32'h0, 26'h0);
        #1;
        check("ill_err", err, 1);
        check("ill_we", imem_we, 0);
        check("ill_ready", op_ready, 1);
        cycle();
        check("ill_count", wlog.size(), 0);

        // Asynchronous reset while the second li word is on the bus
        pulse_start();
        send(19, 0, 8, 0, 0, 32'hDEADBEEF, 26'h0);
        cycle();
        #1;
        compare();
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_we", imem_we, 0);
        check("arst_addr", imem_addr, 0);
        check("arst_wdata", imem_wdata, 0);
        check("arst_words", words_written, 0);
        check("arst_full", full, 0);
        check("arst_err", err, 0);
        check("arst_ready", op_ready, 0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        cycle();
        check("arst_after_words", words_written, 0);

        // Random commands with occasional start
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 99) < 4);
            op_valid = ($urandom_range(0, 99) < 70);
            op_id    = 5'($urandom_range(0, 22));
            rs       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            shamt    = 5'($urandom);
            imm      = ($urandom_range(0, 1) == 1) ? {16'h0, 16'($urandom)} : $urandom;
            target   = 26'($urandom);
            cycle();
        end
        start    = 1'b0;
        op_valid = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
